// File: rtl/cic_chan_sched_pkg.sv
// Shared types for the CIC channel scheduler.
// Holds the scheduler FSM state encoding and the channel-index width helper.
package memcic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    // Bits needed to index n channels; never less than one.
    function automatic int chan_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cic_chan_sched_if.sv
// Request/grant bundle between the scheduler and its round-robin arbiter.
// master: drives req (pending vector) and last (last granted index); slave: returns grant/idx.
interface cic_chan_sched_if #(
    parameter int CHANNELS = 4
);
    localparam int IW = memcic_pkg::chan_w(CHANNELS);

    logic [CHANNELS-1:0] req;
    logic [IW-1:0]       last;
    logic [CHANNELS-1:0] grant;
    logic [IW-1:0]       idx;

    modport master (output req, last, input grant, idx);
    modport slave  (input req, last, output grant, idx);

endinterface

// File: rtl/cic_chan_sched_rr_arbiter.sv
// Round-robin arbiter: searches req starting one past last, wrapping to 0.
// Ports: arb (slave) -- req/last in, one-hot grant and its index out.
module rr_arbiter
    import memcic_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    cic_chan_sched_if.slave arb
);
    localparam int IW = chan_w(CHANNELS);

    logic [CHANNELS-1:0] grant;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       cand;
    logic                found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        // Offsets 1..CHANNELS: last granted channel is tried last.
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = IW'((int'(arb.last) + i) % CHANNELS);
            if (!found && arb.req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign arb.grant = grant;
    assign arb.idx   = idx;

endmodule

// File: rtl/cic_chan_sched.sv
// Time-multiplexes CHANNELS sample streams onto one shared CIC decimator input.
// Ports: ch_data_i/ch_val_i per-channel samples, ovf_clr_i clears sticky ovf_o;
// cic_data_o/cic_val_o/cic_chan_o registered issue bus; busy_o work outstanding.
module cic_chan_sched
    import memcic_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int GAP      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CHANNELS*WIDTH-1:0]     ch_data_i,
    input  logic [CHANNELS-1:0]           ch_val_i,
    input  logic                          ovf_clr_i,
    output logic [WIDTH-1:0]              cic_data_o,
    output logic                          cic_val_o,
    output logic [$clog2(CHANNELS)-1:0]   cic_chan_o,
    output logic [CHANNELS-1:0]           ovf_o,
    output logic                          busy_o
);
    localparam int IW = chan_w(CHANNELS);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] pend_q;
    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [IW-1:0]       last_q;
    logic [GW-1:0]       gap_q, gap_d;
    logic                issue;
    logic [CHANNELS-1:0] clr_mask;
    logic [CHANNELS-1:0] ovf_set;

    cic_chan_sched_if #(.CHANNELS(CHANNELS)) arb ();

    assign arb.req  = pend_q;
    assign arb.last = last_q;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (.arb(arb));

    always_comb begin
        issue    = 1'b0;
        gap_d    = gap_q;
        state_d  = state_q;
        clr_mask = '0;
        unique case (state_q)
            ST_IDLE, ST_ISSUE: issue = (gap_q == '0) && (|pend_q);
            ST_HOLD:           issue = 1'b0;
            default:           issue = 1'b0;
        endcase
        if (issue) begin
            gap_d    = GW'(GAP - 1);
            clr_mask = arb.grant;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
        unique case (state_q)
            ST_IDLE:  state_d = issue ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = issue ? ST_ISSUE
                              : ((gap_d != '0) ? ST_HOLD : ST_IDLE);
            ST_HOLD:  state_d = (gap_d != '0) ? ST_HOLD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A new sample on the channel being granted replaces the issued one
    // without loss, so only non-granted pending channels flag overflow.
    assign ovf_set = ch_val_i & pend_q & ~clr_mask;
    assign busy_o  = (|pend_q) || (gap_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            last_q     <= IW'(CHANNELS - 1);
            gap_q      <= '0;
            ovf_o      <= '0;
            cic_val_o  <= 1'b0;
            cic_data_o <= '0;
            cic_chan_o <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            cic_val_o <= issue;
            pend_q    <= (pend_q & ~clr_mask) | ch_val_i;
            ovf_o     <= (ovf_clr_i ? '0 : ovf_o) | ovf_set;
            if (issue) begin
                cic_data_o <= data_q[arb.idx];
                cic_chan_o <= arb.idx;
                last_q     <= arb.idx;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (ch_val_i[k]) begin
                    data_q[k] <= ch_data_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule
